// File: rtl/val_debouncer_pkg.sv
// Shared constants and state encoding for the switch debouncer.
// Defaults assume a 50 MHz clock (50000 cycles = 1 ms).
package val_debouncer_pkg;

    localparam int DEF_STABLE_CYCLES = 50000;
    localparam int DEF_CNT_WIDTH     = 16;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: 2-flop synchronizer, stability counter, 2-state FSM
// and registered rise/fall pulses coincident with the VAL update.
module debounce_channel
    import val_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW,
    output logic VAL,
    output logic RISE,
    output logic FALL
);

    localparam longint MAX_CYCLES = (longint'(1) << CNT_WIDTH) - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > MAX_CYCLES) begin : g_bad_cycles
        $error("debounce_channel: STABLE_CYCLES out of range for CNT_WIDTH");
    end

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    db_state_e            state_q, state_d;
    logic                 val_q, val_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    always_comb begin
        s1_d    = SW;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        val_d   = val_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s2_q != val_q) begin
                    // A one-cycle requirement is satisfied by the first differing sample.
                    if (STABLE_CYCLES == 1) begin
                        val_d  = s2_q;
                        rise_d = s2_q;
                        fall_d = ~s2_q;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_COUNTING;
                    end
                end
            end
            ST_COUNTING: begin
                if (s2_q == val_q) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    val_d   = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_STABLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_STABLE;
            val_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            val_q   <= val_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign VAL  = val_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

endmodule

// File: rtl/val_debouncer.sv
// Debounces WIDTH raw switch inputs into the VAL bus for the LED stage,
// with per-channel one-cycle edge pulses.
module val_debouncer
    import val_debouncer_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW_IN,
    output logic [WIDTH-1:0] VAL,
    output logic [WIDTH-1:0] VAL_RISE,
    output logic [WIDTH-1:0] VAL_FALL
);

    if (WIDTH < 1) begin : g_bad_width
        $error("val_debouncer: WIDTH must be at least 1");
    end

    debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_WIDTH    (CNT_WIDTH)
    ) inst_ch[WIDTH-1:0] (
        .CLK (CLK),
        .RST (RST),
        .SW  (SW_IN),
        .VAL (VAL),
        .RISE(VAL_RISE),
        .FALL(VAL_FALL)
    );

endmodule
